// File: rtl/pe_wb_arbiter.sv
// Writeback arbiter for the PE register file write port: EX results have priority,
// long-latency results queue in a small FIFO and are tracked in a pending scoreboard.
module pe_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_INDEX_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                         iClk,
  input  logic                         iReset,
  input  logic                         iEX_WB_Valid,
  input  logic [RF_INDEX_WIDTH-1:0]    iEX_WB_Addr,
  input  logic [DATA_WIDTH-1:0]        iEX_WB_Data,
  input  logic                         iLD_WB_Valid,
  output logic                         oLD_WB_Ready,
  input  logic [RF_INDEX_WIDTH-1:0]    iLD_WB_Addr,
  input  logic [DATA_WIDTH-1:0]        iLD_WB_Data,
  output logic [RF_INDEX_WIDTH-1:0]    oWB_RF_Write_Addr,
  output logic [DATA_WIDTH-1:0]        oWB_RF_Write_Data,
  output logic                         oWB_RF_Write_Enable,
  output logic                         oWB_Stall,
  output logic [2**RF_INDEX_WIDTH-1:0] oWB_Pending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 2**RF_INDEX_WIDTH;

  logic [RF_INDEX_WIDTH-1:0] addrMem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     dataMem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     slotValid;
  logic [FIFO_DEPTH-1:0]     slotValidNext;
  logic [PTR_W-1:0]          rdPtr;
  logic [PTR_W-1:0]          wrPtr;
  logic [PTR_W-1:0]          wrPtrNext;
  logic [CNT_W-1:0]          starveCnt;
  logic [CNT_W-1:0]          starveCntNext;
  logic [NREG-1:0]           pendingNext;
  logic                      exEff;
  logic                      fifoEmpty;
  logic                      pop;
  logic                      push;

  assign exEff     = iEX_WB_Valid && (iEX_WB_Addr >= RF_INDEX_WIDTH'(2));
  assign fifoEmpty = !slotValid[rdPtr];
  assign pop       = !exEff && !fifoEmpty;
  assign push      = iLD_WB_Valid && oLD_WB_Ready && (iLD_WB_Addr >= RF_INDEX_WIDTH'(2));
  assign wrPtrNext = push ? wrPtr + PTR_W'(1) : wrPtr;

  // Pending is rebuilt from the surviving slots, so a popped register stays set
  // while any other queued entry (or this cycle's push) still targets it.
  always_comb begin
    slotValidNext = slotValid;
    if (pop)  slotValidNext[rdPtr] = 1'b0;
    if (push) slotValidNext[wrPtr] = 1'b1;
    pendingNext = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (slotValidNext[i] && !(push && PTR_W'(i) == wrPtr))
        pendingNext[addrMem[PTR_W'(i)]] = 1'b1;
    end
    if (push) pendingNext[iLD_WB_Addr] = 1'b1;
  end

  always_comb begin
    starveCntNext = starveCnt;
    if (pop || fifoEmpty)
      starveCntNext = '0;
    else if (starveCnt < CNT_W'(STARVE_LIMIT))
      starveCntNext = starveCnt + CNT_W'(1);
  end

  always_ff @(posedge iClk) begin
    if (push) begin
      addrMem[wrPtr] <= iLD_WB_Addr;
      dataMem[wrPtr] <= iLD_WB_Data;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      slotValid           <= '0;
      rdPtr               <= '0;
      wrPtr               <= '0;
      starveCnt           <= '0;
      oLD_WB_Ready        <= 1'b0;
      oWB_RF_Write_Addr   <= '0;
      oWB_RF_Write_Data   <= '0;
      oWB_RF_Write_Enable <= 1'b0;
      oWB_Stall           <= 1'b0;
      oWB_Pending         <= '0;
    end else begin
      slotValid    <= slotValidNext;
      wrPtr        <= wrPtrNext;
      starveCnt    <= starveCntNext;
      oLD_WB_Ready <= !slotValidNext[wrPtrNext];
      oWB_Stall    <= (starveCntNext >= CNT_W'(STARVE_LIMIT));
      oWB_Pending  <= pendingNext;
      if (exEff) begin
        oWB_RF_Write_Addr   <= iEX_WB_Addr;
        oWB_RF_Write_Data   <= iEX_WB_Data;
        oWB_RF_Write_Enable <= 1'b1;
      end else if (pop) begin
        oWB_RF_Write_Addr   <= addrMem[rdPtr];
        oWB_RF_Write_Data   <= dataMem[rdPtr];
        oWB_RF_Write_Enable <= 1'b1;
        rdPtr               <= rdPtr + PTR_W'(1);
      end else begin
        oWB_RF_Write_Enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_wb_arbiter.sv
// Self-checking bench for pe_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pe_wb_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          exV, ldV;
  logic [AW-1:0] exA, ldA;
  logic [DW-1:0] exD, ldD;
  logic          ldReady, wrEn, stall;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [31:0]   pending;

  always #5 clk = ~clk;

  pe_wb_arbiter #(
    .DATA_WIDTH(DW), .RF_INDEX_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .iClk(clk), .iReset(rst),
    .iEX_WB_Valid(exV), .iEX_WB_Addr(exA), .iEX_WB_Data(exD),
    .iLD_WB_Valid(ldV), .oLD_WB_Ready(ldReady), .iLD_WB_Addr(ldA), .iLD_WB_Data(ldD),
    .oWB_RF_Write_Addr(wrAddr), .oWB_RF_Write_Data(wrData),
    .oWB_RF_Write_Enable(wrEn), .oWB_Stall(stall), .oWB_Pending(pending)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic          mEn, mStall, mReady;
  int            waits;

  function automatic logic [31:0] mPending();
    logic [31:0] p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    return p;
  endfunction

  // Reference: EX (addr>=2) wins, else oldest queued entry; waits counts
  // consecutive cycles with a non-empty queue and no drain.
  task automatic modelStep();
    logic accept;
    logic drained;
    int   sizeBefore;
    if (rst) begin
      q.delete();
      mAddr = '0; mData = '0; mEn = 0; mStall = 0; mReady = 0; waits = 0;
      return;
    end
    accept = ldV && mReady;
    sizeBefore = q.size();
    drained = 0;
    if (exV && exA >= 2) begin
      mAddr = exA; mData = exD; mEn = 1;
    end else if (q.size() > 0) begin
      mAddr = q[0].a; mData = q[0].d; mEn = 1; drained = 1;
      void'(q.pop_front());
    end else begin
      mEn = 0;
    end
    if (accept && ldA >= 2) q.push_back('{a: ldA, d: ldD});
    if (drained || sizeBefore == 0) waits = 0;
    else if (waits < LIMIT) waits++;
    mStall = (waits >= LIMIT);
    mReady = (q.size() < DEPTH);
  endtask

  task automatic step(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic r);
    exV = ev; exA = ea; exD = ed; ldV = lv; ldA = la; ldD = ld; rst = r;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic test_reset();
    step(0, '0, '0, 0, '0, '0, 1);
    step(0, '0, '0, 0, '0, '0, 1);
    checks++; if (wrEn !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", wrEn); end
    checks++; if (ldReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ldReady); end
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (wrAddr !== 5'd0 || wrData !== 32'h0) begin errors++; $display("FAIL reset_addrdata got %0d/%h exp 0/0", wrAddr, wrData); end
    idle();
    checks++; if (ldReady !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", ldReady); end
    checks++; if (wrEn !== 1'b0) begin errors++; $display("FAIL idle_en got %b exp 0", wrEn); end
  endtask

  task automatic test_ex_write();
    step(1, 5'd5, 32'h1234, 0, '0, '0, 0);
    checks++; if (wrEn !== 1'b1 || wrAddr !== 5'd5 || wrData !== 32'h1234) begin
      errors++; $display("FAIL ex_write got en=%b a=%0d d=%h exp en=1 a=5 d=1234", wrEn, wrAddr, wrData); end
    idle();
    checks++; if (wrEn !== 1'b0 || wrAddr !== 5'd5) begin
      errors++; $display("FAIL ex_one_cycle got en=%b a=%0d exp en=0 a=5", wrEn, wrAddr); end
  endtask

  task automatic test_ld_write();
    step(0, '0, '0, 1, 5'd7, 32'hAAAA, 0);
    checks++; if (wrEn !== 1'b0 || pending !== 32'h80) begin
      errors++; $display("FAIL ld_pending got en=%b p=%h exp en=0 p=00000080", wrEn, pending); end
    idle();
    checks++; if (wrEn !== 1'b1 || wrAddr !== 5'd7 || wrData !== 32'hAAAA) begin
      errors++; $display("FAIL ld_write got en=%b a=%0d d=%h exp en=1 a=7 d=aaaa", wrEn, wrAddr, wrData); end
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL ld_pending_clear got %h exp 0", pending); end
    idle();
    checks++; if (wrEn !== 1'b0) begin errors++; $display("FAIL ld_one_cycle got %b exp 0", wrEn); end
  endtask

  task automatic test_full_starve();
    step(1, 5'd10, 32'h10, 1, 5'd3, 32'h333, 0);
    checks++; if (ldReady !== 1'b1 || pending !== 32'h8) begin
      errors++; $display("FAIL fill1 got rdy=%b p=%h exp rdy=1 p=00000008", ldReady, pending); end
    step(1, 5'd11, 32'h11, 1, 5'd4, 32'h444, 0);
    checks++; if (ldReady !== 1'b0 || pending !== 32'h18) begin
      errors++; $display("FAIL full got rdy=%b p=%h exp rdy=0 p=00000018", ldReady, pending); end
    step(1, 5'd12, 32'h12, 1, 5'd12, 32'hC, 0);
    checks++; if (pending !== 32'h18 || stall !== 1'b0) begin
      errors++; $display("FAIL full_reject got p=%h st=%b exp p=00000018 st=0", pending, stall); end
    step(1, 5'd13, 32'h13, 0, '0, '0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_early got %b exp 0", stall); end
    step(1, 5'd14, 32'h14, 0, '0, '0, 0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_limit got %b exp 1", stall); end
    step(1, 5'd15, 32'h15, 0, '0, '0, 0);
    checks++; if (wrAddr !== 5'd15 || wrEn !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL ex_wins_stalled got a=%0d en=%b st=%b exp a=15 en=1 st=1", wrAddr, wrEn, stall); end
    idle();
    checks++; if (wrEn !== 1'b1 || wrAddr !== 5'd3 || wrData !== 32'h333 || stall !== 1'b0 || ldReady !== 1'b1) begin
      errors++; $display("FAIL drain_r3 got en=%b a=%0d d=%h st=%b rdy=%b exp 1/3/333/0/1", wrEn, wrAddr, wrData, stall, ldReady); end
    idle();
    checks++; if (wrEn !== 1'b1 || wrAddr !== 5'd4 || wrData !== 32'h444 || pending !== 32'h0) begin
      errors++; $display("FAIL drain_r4 got en=%b a=%0d d=%h p=%h exp 1/4/444/0", wrEn, wrAddr, wrData, pending); end
    idle();
    checks++; if (wrEn !== 1'b0) begin errors++; $display("FAIL drain_done got %b exp 0", wrEn); end
  endtask

  task automatic test_reserved();
    step(1, 5'd2, 32'h22, 1, 5'd9, 32'h999, 0);
    checks++; if (ldReady !== 1'b1) begin errors++; $display("FAIL rsv_ready got %b exp 1", ldReady); end
    step(1, 5'd1, 32'hDEAD, 1, 5'd0, 32'hBEEF, 0);
    checks++; if (wrEn !== 1'b1 || wrAddr !== 5'd9 || wrData !== 32'h999 || pending !== 32'h0) begin
      errors++; $display("FAIL rsv_pop got en=%b a=%0d d=%h p=%h exp 1/9/999/0", wrEn, wrAddr, wrData, pending); end
    idle();
    checks++; if (wrEn !== 1'b0 || ldReady !== 1'b1) begin
      errors++; $display("FAIL rsv_discard got en=%b rdy=%b exp 0/1", wrEn, ldReady); end
  endtask

  task automatic test_reset_mid();
    step(1, 5'd20, 32'h20, 1, 5'd6, 32'hA6, 0);
    step(1, 5'd21, 32'h21, 1, 5'd6, 32'hB6, 0);
    step(0, '0, '0, 0, '0, '0, 1);
    checks++; if (wrEn !== 1'b0 || pending !== 32'h0) begin
      errors++; $display("FAIL mid_reset got en=%b p=%h exp 0/0", wrEn, pending); end
    idle();
    checks++; if (wrEn !== 1'b0) begin errors++; $display("FAIL mid_reset_flush got %b exp 0", wrEn); end
    step(1, 5'd20, 32'h20, 1, 5'd6, 32'hA6, 0);
    step(1, 5'd21, 32'h21, 1, 5'd6, 32'hB6, 0);
    idle();
    checks++; if (wrAddr !== 5'd6 || wrData !== 32'hA6 || pending !== 32'h40) begin
      errors++; $display("FAIL dup_first got a=%0d d=%h p=%h exp 6/a6/00000040", wrAddr, wrData, pending); end
    idle();
    checks++; if (wrData !== 32'hB6 || pending !== 32'h0) begin
      errors++; $display("FAIL dup_second got d=%h p=%h exp b6/0", wrData, pending); end
  endtask

  task automatic test_random();
    logic ev;
    for (int n = 0; n < 600; n++) begin
      ev = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      step(ev, AW'($urandom_range(0, 9)), $urandom(),
           $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom(),
           $urandom_range(0, 99) == 0);
      checks++;
      if (wrEn !== mEn || wrAddr !== mAddr || wrData !== mData || ldReady !== mReady ||
          stall !== mStall || pending !== mPending()) begin
        errors++;
        $display("FAIL rand_cycle%0d got en=%b a=%0d d=%h rdy=%b st=%b p=%h exp en=%b a=%0d d=%h rdy=%b st=%b p=%h",
                 n, wrEn, wrAddr, wrData, ldReady, stall, pending,
                 mEn, mAddr, mData, mReady, mStall, mPending());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ex_write();
    test_ld_write();
    test_full_starve();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
